// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared FSM state type and slice-count helper for cla_seq_adder
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns 0 for an illegal WIDTH/GROUP pair so the top can refuse to elaborate.
  function automatic int num_groups(input int width, input int group);
    if (group < 1 || width < group || (width % group) != 0) return 0;
    return width / group;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// rtl/cla_seq_adder_if.sv - operand/result handshake bundle; o_ovf present with CLA_SEQ_ADDER_OVF_EN
interface cla_seq_adder_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_c;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_c;
  logic             o_g;
  logic             o_p;
`ifdef CLA_SEQ_ADDER_OVF_EN
  logic             o_ovf;
`endif

  modport slave (
    input  i_valid, i_a, i_b, i_c, i_ready,
    output o_ready, o_valid, o_s, o_c, o_g, o_p
`ifdef CLA_SEQ_ADDER_OVF_EN
    , output o_ovf
`endif
  );

  modport master (
    output i_valid, i_a, i_b, i_c, i_ready,
    input  o_ready, o_valid, o_s, o_c, o_g, o_p
`ifdef CLA_SEQ_ADDER_OVF_EN
    , input o_ovf
`endif
  );

endinterface

// File: rtl/cla_gp_slice.sv
// rtl/cla_gp_slice.sv - combinational GROUP-bit slice: sum, carry-out, group generate/propagate
module cla_gp_slice #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             c_i,
  output logic [GROUP-1:0] s_o,
  output logic             c_o,
  output logic             g_o,
  output logic             p_o
);

  logic [GROUP:0] c;

  // OR-propagate: p = a | b, so G_k is simply the slice carry-out with carry-in forced to 0.
  always_comb begin
    c    = '0;
    s_o  = '0;
    g_o  = 1'b0;
    p_o  = 1'b1;
    c[0] = c_i;
    for (int j = 0; j < GROUP; j++) begin
      c[j+1] = (a_i[j] & b_i[j]) | ((a_i[j] | b_i[j]) & c[j]);
      s_o[j] = a_i[j] ^ b_i[j] ^ c[j];
      g_o    = (a_i[j] & b_i[j]) | ((a_i[j] | b_i[j]) & g_o);
      p_o    = p_o & (a_i[j] | b_i[j]);
    end
    c_o = c[GROUP];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle slice-serial carry-lookahead adder with valid/ready handshakes
// Optional signed-overflow output enabled by CLA_SEQ_ADDER_OVF_EN.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cla_seq_adder_if.slave bus
);

  localparam int NUM_GROUPS = num_groups(WIDTH, GROUP);
  localparam int KW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (NUM_GROUPS < 1) begin : g_bad_cfg
    $error("cla_seq_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, s_q, s_d;
  logic             carry_q, carry_d, g_acc_q, g_acc_d, p_acc_q, p_acc_d;
  logic             c_q, c_d, g_q, g_d, p_q, p_d;
`ifdef CLA_SEQ_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [GROUP-1:0] slice_a, slice_b, slice_s;
  logic             slice_co, slice_g, slice_p, last_slice;

  assign slice_a    = GROUP'(a_q >> (int'(k_q) * GROUP));
  assign slice_b    = GROUP'(b_q >> (int'(k_q) * GROUP));
  assign last_slice = (k_q == KW'(NUM_GROUPS - 1));

  cla_gp_slice #(.GROUP(GROUP)) u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_co),
    .g_o (slice_g),
    .p_o (slice_p)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    g_acc_d = g_acc_q;
    p_acc_d = p_acc_q;
    s_d     = s_q;
    c_d     = c_q;
    g_d     = g_q;
    p_d     = p_q;
`ifdef CLA_SEQ_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          carry_d = bus.i_c;
          k_d     = '0;
          work_d  = '0;
          g_acc_d = 1'b0;
          p_acc_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = work_q | (WIDTH'(slice_s) << (int'(k_q) * GROUP));
        carry_d = slice_co;
        g_acc_d = slice_g | (slice_p & g_acc_q);
        p_acc_d = slice_p & p_acc_q;
        if (last_slice) begin
          // Published results change only here, so they stay stable through DONE and IDLE.
          s_d     = work_d;
          c_d     = slice_co;
          g_d     = g_acc_d;
          p_d     = p_acc_d;
`ifdef CLA_SEQ_ADDER_OVF_EN
          ovf_d   = slice_a[GROUP-1] ^ slice_b[GROUP-1] ^ slice_s[GROUP-1] ^ slice_co;
`endif
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      g_acc_q <= 1'b0;
      p_acc_q <= 1'b1;
      s_q     <= '0;
      c_q     <= 1'b0;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
`ifdef CLA_SEQ_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      g_acc_q <= g_acc_d;
      p_acc_q <= p_acc_d;
      s_q     <= s_d;
      c_q     <= c_d;
      g_q     <= g_d;
      p_q     <= p_d;
`ifdef CLA_SEQ_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_s     = s_q;
  assign bus.o_c     = c_q;
  assign bus.o_g     = g_q;
  assign bus.o_p     = p_q;
`ifdef CLA_SEQ_ADDER_OVF_EN
  assign bus.o_ovf   = ovf_q;
`endif

endmodule
